// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types and helpers for the scanning N:1 mux
package mux_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } mode_e;

    typedef mode_e state_t;

    // Bit offset of channel ch inside the packed in_data bus.
    function automatic int ch_lsb(input int ch, input int w);
        return ch * w;
    endfunction

    // Dwell counter width; a single-cycle dwell still needs one bit.
    function automatic int cnt_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - modulo-DWELL cycle counter with terminal-count tick
module dwell_counter
    import mux_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = cnt_width(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/mux_nto1_scan.sv
// rtl/mux_nto1_scan.sv - registered N:1 mux with manual select and auto-scan
module mux_nto1_scan
    import mux_pkg::*;
#(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int DWELL = 4,
    parameter int SW    = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [SW-1:0]  sel,
    input  logic           mode,
    input  logic           hold,
    output logic [W-1:0]   out,
    output logic [SW-1:0]  cur_ch,
    output logic           ch_wrap
);

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] cur_ch_next;
    logic          wrap_next;
    logic [W-1:0]  out_next;
    logic          cnt_clr;
    logic          cnt_en;
    logic          tick;

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= MANUAL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = mode ? SCAN : MANUAL;
    end

    // Entering SCAN takes sel like MANUAL does, so hold is ignored on that edge.
    always_comb begin
        cur_ch_next = cur_ch;
        wrap_next   = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        if (state_next == MANUAL || state == MANUAL) begin
            cur_ch_next = sel;
            cnt_clr     = 1'b1;
        end else if (!hold) begin
            cnt_en = 1'b1;
            if (tick) begin
                if (int'(cur_ch) == N - 1) begin
                    cur_ch_next = '0;
                    wrap_next   = 1'b1;
                end else if (int'(cur_ch) < N - 1) begin
                    cur_ch_next = cur_ch + SW'(1);
                end else begin
                    cur_ch_next = '0;
                end
            end
        end
    end

    // Out-of-range channel indices fall through to zero.
    always_comb begin
        out_next = '0;
        for (int k = 0; k < N; k++) begin
            if (cur_ch_next == SW'(k)) begin
                out_next = in_data[ch_lsb(k, W) +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out     <= '0;
            cur_ch  <= '0;
            ch_wrap <= 1'b0;
        end else begin
            out     <= out_next;
            cur_ch  <= cur_ch_next;
            ch_wrap <= wrap_next;
        end
    end

endmodule
